pckt_src_arbiter: RTL

Packet-granular round-robin arbiter that shares the single input port of pckt_decoder_top among NSRC packet sources. It grants one source per packet, holds the grant from sop to eop, and forwards beats as in_valid/in_sop/in_eop/in_data/in_empty/in_error. It honours the decoder's active-low backpressure, ready_out_b, and closes malformed packets with a synthesized error terminator beat.

---
 rtl/pckt_src_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pckt_src_arbiter.sv
// Packet-granular round-robin arbiter sharing the decoder input among NSRC sources; optional stall watchdog under `PKT_WDOG_EN`.
// Latency: 1 cycle from accept to out_*; at least one idle cycle between packets.
// Backpressure: ready_out_b=1 blocks every accept and holds out_* with out_valid=0.
module pckt_src_arbiter #(
    parameter int NSRC        = 4,
    parameter int IWIDTH      = 8,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                     clk_tb,
    input  logic                     rstb,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC-1:0]          src_sop,
    input  logic [NSRC-1:0]          src_eop,
    input  logic [NSRC*IWIDTH*8-1:0] src_data,
    input  logic [NSRC*IWIDTH-1:0]   src_empty,
    input  logic [NSRC-1:0]          src_error,
    output logic [NSRC-1:0]          src_ready,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [IWIDTH*8-1:0]      out_data,
    output logic [IWIDTH-1:0]        out_empty,
    output logic                     out_error,
    input  logic                     ready_out_b,
    output logic [$clog2(NSRC)-1:0]  grant_id,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         abort_cnt
);
    localparam int GW = $clog2(NSRC);
    localparam int DW = IWIDTH * 8;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ABORT} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     rr_ptr, rr_nxt, grant_nxt, pick;
    logic              first_beat, first_nxt, found;
    logic [NSRC-1:0]   req, discard;
    logic              g_valid, g_sop, g_eop, g_err;
    logic [DW-1:0]     g_data;
    logic [IWIDTH-1:0] g_empty;
    logic              sop_viol, accept, term, wdog_hit;
    logic [3:0]        abort_inc;
    logic [CNT_W+3:0]  abort_sum;

    assign req     = src_valid & src_sop;
    assign discard = src_valid & ~src_sop;

    assign g_valid = src_valid[grant_id];
    assign g_sop   = src_sop[grant_id];
    assign g_eop   = src_eop[grant_id];
    assign g_err   = src_error[grant_id];
    assign g_data  = src_data[grant_id*DW +: DW];
    assign g_empty = src_empty[grant_id*IWIDTH +: IWIDTH];

    // A fresh sop from the granted source before its eop means the packet was never closed.
    assign sop_viol = (state == S_XFER) & g_valid & g_sop & ~first_beat;
    assign accept   = (state == S_XFER) & g_valid & ~ready_out_b & ~sop_viol;
    assign term     = (state == S_ABORT) & ~ready_out_b;

    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NSRC; i++) begin
            idx = (int'(rr_ptr) + i) % NSRC;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        first_nxt = first_beat;
        src_ready = '0;
        abort_inc = '0;
        case (state)
            S_IDLE: begin
                src_ready = discard;
                abort_inc = 4'($countones(discard));
                if (found) begin
                    grant_nxt = pick;
                    first_nxt = 1'b1;
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                src_ready[grant_id] = ~ready_out_b & ~sop_viol;
                if (sop_viol) begin
                    state_nxt = S_ABORT;
                end else if (accept) begin
                    first_nxt = 1'b0;
                    if (g_eop) begin
                        rr_nxt    = grant_id;
                        state_nxt = S_IDLE;
                    end
                end else if (wdog_hit) begin
                    rr_nxt    = grant_id;
                    state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                if (term) begin
                    abort_inc = 4'd1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!rstb) src_ready = '0;
    end

    assign abort_sum = {4'b0, abort_cnt} + (CNT_W+4)'(abort_inc);

    always_ff @(posedge clk_tb or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            rr_ptr     <= GW'(NSRC - 1);
            grant_id   <= '0;
            first_beat <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
            out_empty  <= '0;
            out_error  <= 1'b0;
            pkt_cnt    <= '0;
            abort_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            grant_id   <= grant_nxt;
            first_beat <= first_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_sop   <= g_sop;
                out_eop   <= g_eop;
                out_data  <= g_data;
                out_empty <= g_empty;
                out_error <= g_err;
            end else if (term) begin
                out_valid <= 1'b1;
                out_sop   <= 1'b0;
                out_eop   <= 1'b1;
                out_data  <= '0;
                out_empty <= '1;
                out_error <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
            if (accept && g_eop && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + 1'b1;
            abort_cnt <= (abort_sum > {4'b0, {CNT_W{1'b1}}}) ? '1 : abort_sum[CNT_W-1:0];
        end
    end

`ifdef PKT_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;
    logic          stall;

    assign stall    = (state == S_XFER) & ~ready_out_b & ~accept & ~sop_viol;
    assign wdog_hit = stall & (wdog_cnt == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_tb or negedge rstb) begin
        if (!rstb)                  wdog_cnt <= '0;
        else if (stall && !wdog_hit) wdog_cnt <= wdog_cnt + 1'b1;
        else                         wdog_cnt <= '0;
    end
`else
    // No timeout: the grant is held for as long as the source stays silent.
    assign wdog_hit = (WDOG_CYCLES < 0);
`endif

endmodule
